// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared decode constants and the packed instruction-queue entry
// Field widths, one-hot instruction formats, functional unit codes, operand
// access flags and the entry layout stored by decode_inst_queue.
package decode_pkg;

   localparam int opcodeSize              = 12;
   localparam int addressWidth            = 64;
   localparam int instructionCounterWidth = 64;
   localparam int instMinIdWidth          = 5;
   localparam int PidSize                 = 32;
   localparam int TidSize                 = 64;
   localparam int funcUnitCodeSize        = 3;
   localparam int regAccessPatternSize    = 2;
   localparam int formatWidth             = 25;
   localparam int bodyWidth               = 64;

   // One-hot instruction formats
   localparam logic [formatWidth-1:0] FMT_I  = formatWidth'(1) << 0;
   localparam logic [formatWidth-1:0] FMT_B  = formatWidth'(1) << 1;
   localparam logic [formatWidth-1:0] FMT_D  = formatWidth'(1) << 2;
   localparam logic [formatWidth-1:0] FMT_A  = formatWidth'(1) << 3;
   localparam logic [formatWidth-1:0] FMT_X  = formatWidth'(1) << 4;
   localparam logic [formatWidth-1:0] FMT_XO = formatWidth'(1) << 5;
   localparam logic [formatWidth-1:0] FMT_M  = formatWidth'(1) << 6;
   localparam logic [formatWidth-1:0] FMT_MD = formatWidth'(1) << 7;

   // Functional unit codes
   localparam logic [funcUnitCodeSize-1:0] FU_INT    = 3'd0;
   localparam logic [funcUnitCodeSize-1:0] FU_FP     = 3'd1;
   localparam logic [funcUnitCodeSize-1:0] FU_LDST   = 3'd2;
   localparam logic [funcUnitCodeSize-1:0] FU_BRANCH = 3'd3;
   localparam logic [funcUnitCodeSize-1:0] FU_CR     = 3'd4;
   localparam logic [funcUnitCodeSize-1:0] FU_SYS    = 3'd5;

   // Operand access flags
   localparam logic [regAccessPatternSize-1:0] REG_READ  = 2'b01;
   localparam logic [regAccessPatternSize-1:0] REG_WRITE = 2'b10;

   typedef struct packed {
      logic [formatWidth-1:0]             inst_format;
      logic [opcodeSize-1:0]              opcode;
      logic [addressWidth-1:0]            address;
      logic [funcUnitCodeSize-1:0]        func_unit_type;
      logic [instructionCounterWidth-1:0] maj_id;
      logic [instMinIdWidth-1:0]          min_id;
      logic [instMinIdWidth-1:0]          num_micro_ops;
      logic                               is_64bit;
      logic [PidSize-1:0]                 pid;
      logic [TidSize-1:0]                 tid;
      logic [regAccessPatternSize-1:0]    op1rw;
      logic [regAccessPatternSize-1:0]    op2rw;
      logic [regAccessPatternSize-1:0]    op3rw;
      logic [regAccessPatternSize-1:0]    op4rw;
      logic                               op1_is_reg;
      logic                               op2_is_reg;
      logic                               op3_is_reg;
      logic                               op4_is_reg;
      logic                               modifies_cr;
      logic [bodyWidth-1:0]               body;
   } entry_t;

   localparam int entryWidth = $bits(entry_t);

endpackage

// File: rtl/decode_fifo_ctrl.sv
// rtl/decode_fifo_ctrl.sv - pointer, occupancy, stall and overflow control for the decode queue
// Optional build macro: DECODE_QUEUE_STATS_EN (push/pop/drop counters).
// Ports:
//   i_clock, i_reset (async, active-high), i_flush (sync clear)
//   i_enable  : beat offered this cycle (no backpressure upstream)
//   i_ready   : dispatch accepts the head entry
//   o_wr_en / o_wr_ptr : storage write strobe and slot
//   o_rd_ptr  : head slot
//   o_valid, o_count, o_stall, o_overflow : queue status
//   o_push_count / o_pop_count / o_drop_count : statistics (macro only)
module decode_fifo_ctrl #(
   parameter int depth      = 8,
   parameter int stallSlack = 3
) (
   input  logic                       i_clock,
   input  logic                       i_reset,
   input  logic                       i_flush,
   input  logic                       i_enable,
   input  logic                       i_ready,
   output logic                       o_wr_en,
   output logic [$clog2(depth)-1:0]   o_wr_ptr,
   output logic [$clog2(depth)-1:0]   o_rd_ptr,
   output logic                       o_valid,
   output logic [$clog2(depth):0]     o_count,
   output logic                       o_stall,
`ifdef DECODE_QUEUE_STATS_EN
   output logic [31:0]                o_push_count,
   output logic [31:0]                o_pop_count,
   output logic [31:0]                o_drop_count,
`endif
   output logic                       o_overflow
);
   localparam int PTR_W = $clog2(depth);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_stall;
   logic [CNT_W-1:0] w_count_next;
   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;

   assign w_full  = (r_count == CNT_W'(depth));
   assign w_empty = (r_count == '0);
   assign w_pop   = !w_empty && i_ready && !i_flush;
   // A full queue still takes a beat when the head leaves in the same cycle.
   assign w_push  = i_enable && (!w_full || w_pop) && !i_flush;
   assign w_drop  = i_enable && w_full && !w_pop && !i_flush;

   always_comb begin
      w_count_next = r_count;
      if (i_flush)
         w_count_next = '0;
      else if (w_push && !w_pop)
         w_count_next = r_count + CNT_W'(1);
      else if (w_pop && !w_push)
         w_count_next = r_count - CNT_W'(1);
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_stall  <= 1'b0;
      end else begin
         r_count <= w_count_next;
         // Registered early warning, sized so in-flight decode beats still fit.
         r_stall <= (w_count_next >= CNT_W'(depth - stallSlack));
         if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
      end
   end

`ifdef DECODE_QUEUE_STATS_EN
   logic [31:0] r_push_count;
   logic [31:0] r_pop_count;
   logic [31:0] r_drop_count;

   // Statistics deliberately survive flush; only reset clears them.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_push_count <= '0;
         r_pop_count  <= '0;
         r_drop_count <= '0;
      end else begin
         if (w_push) r_push_count <= r_push_count + 32'd1;
         if (w_pop)  r_pop_count  <= r_pop_count + 32'd1;
         if (w_drop) r_drop_count <= r_drop_count + 32'd1;
      end
   end

   assign o_push_count = r_push_count;
   assign o_pop_count  = r_pop_count;
   assign o_drop_count = r_drop_count;
`endif

   assign o_wr_en    = w_push;
   assign o_wr_ptr   = r_wr_ptr;
   assign o_rd_ptr   = r_rd_ptr;
   assign o_valid    = !w_empty;
   assign o_count    = r_count;
   assign o_stall    = r_stall;
   assign o_overflow = w_drop;

endmodule

// File: rtl/decode_inst_queue.sv
// rtl/decode_inst_queue.sv - decoded instruction FIFO between decode mux and dispatch
// Optional build macro: DECODE_QUEUE_STATS_EN adds pushCount_o/popCount_o/dropCount_o.
// Ports:
//   clock_i, reset_i (async, active-high), flush_i (sync clear)
//   enable_i + *_i fields : decoded beat, no backpressure
//   ready_i               : dispatch takes the head entry
//   valid_o + *_o fields  : head entry, zero while the queue is empty
//   stall_o, overflow_o, count_o : flow control and occupancy
module decode_inst_queue
   import decode_pkg::*;
#(
   parameter int depth      = 8,
   parameter int stallSlack = 3
) (
   input  logic                               clock_i,
   input  logic                               reset_i,
   input  logic                               flush_i,
   input  logic                               enable_i,
   input  logic [formatWidth-1:0]             instFormat_i,
   input  logic [opcodeSize-1:0]              opcode_i,
   input  logic [addressWidth-1:0]            address_i,
   input  logic [funcUnitCodeSize-1:0]        funcUnitType_i,
   input  logic [instructionCounterWidth-1:0] majID_i,
   input  logic [instMinIdWidth-1:0]          minID_i,
   input  logic [instMinIdWidth-1:0]          numMicroOps_i,
   input  logic                               is64Bit_i,
   input  logic [PidSize-1:0]                 pid_i,
   input  logic [TidSize-1:0]                 tid_i,
   input  logic [regAccessPatternSize-1:0]    op1rw_i,
   input  logic [regAccessPatternSize-1:0]    op2rw_i,
   input  logic [regAccessPatternSize-1:0]    op3rw_i,
   input  logic [regAccessPatternSize-1:0]    op4rw_i,
   input  logic                               op1IsReg_i,
   input  logic                               op2IsReg_i,
   input  logic                               op3IsReg_i,
   input  logic                               op4IsReg_i,
   input  logic                               modifiesCR_i,
   input  logic [bodyWidth-1:0]               body_i,
   input  logic                               ready_i,
   output logic                               valid_o,
   output logic [formatWidth-1:0]             instFormat_o,
   output logic [opcodeSize-1:0]              opcode_o,
   output logic [addressWidth-1:0]            address_o,
   output logic [funcUnitCodeSize-1:0]        funcUnitType_o,
   output logic [instructionCounterWidth-1:0] majID_o,
   output logic [instMinIdWidth-1:0]          minID_o,
   output logic [instMinIdWidth-1:0]          numMicroOps_o,
   output logic                               is64Bit_o,
   output logic [PidSize-1:0]                 pid_o,
   output logic [TidSize-1:0]                 tid_o,
   output logic [regAccessPatternSize-1:0]    op1rw_o,
   output logic [regAccessPatternSize-1:0]    op2rw_o,
   output logic [regAccessPatternSize-1:0]    op3rw_o,
   output logic [regAccessPatternSize-1:0]    op4rw_o,
   output logic                               op1IsReg_o,
   output logic                               op2IsReg_o,
   output logic                               op3IsReg_o,
   output logic                               op4IsReg_o,
   output logic                               modifiesCR_o,
   output logic [bodyWidth-1:0]               body_o,
   output logic                               stall_o,
   output logic                               overflow_o,
`ifdef DECODE_QUEUE_STATS_EN
   output logic [31:0]                        pushCount_o,
   output logic [31:0]                        popCount_o,
   output logic [31:0]                        dropCount_o,
`endif
   output logic [$clog2(depth):0]             count_o
);
   localparam int PTR_W = $clog2(depth);

   entry_t             r_mem [depth];
   entry_t             w_in_entry;
   entry_t             w_head;
   logic               w_wr_en;
   logic [PTR_W-1:0]   w_wr_ptr;
   logic [PTR_W-1:0]   w_rd_ptr;
   logic               w_valid;

   decode_fifo_ctrl #(.depth(depth), .stallSlack(stallSlack)) u_ctrl (
      .i_clock      (clock_i),
      .i_reset      (reset_i),
      .i_flush      (flush_i),
      .i_enable     (enable_i),
      .i_ready      (ready_i),
      .o_wr_en      (w_wr_en),
      .o_wr_ptr     (w_wr_ptr),
      .o_rd_ptr     (w_rd_ptr),
      .o_valid      (w_valid),
      .o_count      (count_o),
      .o_stall      (stall_o),
`ifdef DECODE_QUEUE_STATS_EN
      .o_push_count (pushCount_o),
      .o_pop_count  (popCount_o),
      .o_drop_count (dropCount_o),
`endif
      .o_overflow   (overflow_o)
   );

   assign w_in_entry = '{
      inst_format:    instFormat_i,
      opcode:         opcode_i,
      address:        address_i,
      func_unit_type: funcUnitType_i,
      maj_id:         majID_i,
      min_id:         minID_i,
      num_micro_ops:  numMicroOps_i,
      is_64bit:       is64Bit_i,
      pid:            pid_i,
      tid:            tid_i,
      op1rw:          op1rw_i,
      op2rw:          op2rw_i,
      op3rw:          op3rw_i,
      op4rw:          op4rw_i,
      op1_is_reg:     op1IsReg_i,
      op2_is_reg:     op2IsReg_i,
      op3_is_reg:     op3IsReg_i,
      op4_is_reg:     op4IsReg_i,
      modifies_cr:    modifiesCR_i,
      body:           body_i
   };

   // Storage has no reset; stale slots are hidden by gating the head with valid.
   always_ff @(posedge clock_i) begin
      if (w_wr_en) r_mem[w_wr_ptr] <= w_in_entry;
   end

   assign w_head = w_valid ? r_mem[w_rd_ptr] : '0;

   assign valid_o        = w_valid;
   assign instFormat_o   = w_head.inst_format;
   assign opcode_o       = w_head.opcode;
   assign address_o      = w_head.address;
   assign funcUnitType_o = w_head.func_unit_type;
   assign majID_o        = w_head.maj_id;
   assign minID_o        = w_head.min_id;
   assign numMicroOps_o  = w_head.num_micro_ops;
   assign is64Bit_o      = w_head.is_64bit;
   assign pid_o          = w_head.pid;
   assign tid_o          = w_head.tid;
   assign op1rw_o        = w_head.op1rw;
   assign op2rw_o        = w_head.op2rw;
   assign op3rw_o        = w_head.op3rw;
   assign op4rw_o        = w_head.op4rw;
   assign op1IsReg_o     = w_head.op1_is_reg;
   assign op2IsReg_o     = w_head.op2_is_reg;
   assign op3IsReg_o     = w_head.op3_is_reg;
   assign op4IsReg_o     = w_head.op4_is_reg;
   assign modifiesCR_o   = w_head.modifies_cr;
   assign body_o         = w_head.body;

endmodule

// File: tb/tb_decode_inst_queue.sv
// tb/tb_decode_inst_queue.sv - self-checking bench for decode_inst_queue against a queue-based model
// Optional build macro: DECODE_QUEUE_STATS_EN (statistics counters also checked).
module tb_decode_inst_queue;

   localparam int DEPTH = 8;
   localparam int SLACK = 3;

   typedef struct packed {
      logic [24:0] fmt;
      logic [11:0] opc;
      logic [63:0] addr;
      logic [2:0]  fu;
      logic [63:0] maj;
      logic [4:0]  min;
      logic [4:0]  nmu;
      logic        is64;
      logic [31:0] pid;
      logic [63:0] tid;
      logic [1:0]  rw1, rw2, rw3, rw4;
      logic        rg1, rg2, rg3, rg4;
      logic        cr;
      logic [63:0] body;
   } beat_t;

   logic clock_i = 1'b0;
   logic reset_i, flush_i, enable_i, ready_i;
   beat_t in_b;
   beat_t out_b;

   logic        valid_o, stall_o, overflow_o;
   logic [3:0]  count_o;
   logic [24:0] o_fmt;
   logic [11:0] o_opc;
   logic [63:0] o_addr, o_maj, o_tid, o_body;
   logic [2:0]  o_fu;
   logic [4:0]  o_min, o_nmu;
   logic        o_is64, o_rg1, o_rg2, o_rg3, o_rg4, o_cr;
   logic [31:0] o_pid;
   logic [1:0]  o_rw1, o_rw2, o_rw3, o_rw4;
`ifdef DECODE_QUEUE_STATS_EN
   logic [31:0] push_cnt_o, pop_cnt_o, drop_cnt_o;
   int unsigned m_push_n, m_pop_n, m_drop_n;
`endif

   assign out_b = {o_fmt, o_opc, o_addr, o_fu, o_maj, o_min, o_nmu, o_is64, o_pid, o_tid,
                   o_rw1, o_rw2, o_rw3, o_rw4, o_rg1, o_rg2, o_rg3, o_rg4, o_cr, o_body};

   always #5 clock_i = ~clock_i;

   decode_inst_queue #(.depth(DEPTH), .stallSlack(SLACK)) dut (
      .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i), .enable_i(enable_i),
      .instFormat_i(in_b.fmt), .opcode_i(in_b.opc), .address_i(in_b.addr),
      .funcUnitType_i(in_b.fu), .majID_i(in_b.maj), .minID_i(in_b.min),
      .numMicroOps_i(in_b.nmu), .is64Bit_i(in_b.is64), .pid_i(in_b.pid), .tid_i(in_b.tid),
      .op1rw_i(in_b.rw1), .op2rw_i(in_b.rw2), .op3rw_i(in_b.rw3), .op4rw_i(in_b.rw4),
      .op1IsReg_i(in_b.rg1), .op2IsReg_i(in_b.rg2), .op3IsReg_i(in_b.rg3), .op4IsReg_i(in_b.rg4),
      .modifiesCR_i(in_b.cr), .body_i(in_b.body), .ready_i(ready_i),
      .valid_o(valid_o),
      .instFormat_o(o_fmt), .opcode_o(o_opc), .address_o(o_addr), .funcUnitType_o(o_fu),
      .majID_o(o_maj), .minID_o(o_min), .numMicroOps_o(o_nmu), .is64Bit_o(o_is64),
      .pid_o(o_pid), .tid_o(o_tid),
      .op1rw_o(o_rw1), .op2rw_o(o_rw2), .op3rw_o(o_rw3), .op4rw_o(o_rw4),
      .op1IsReg_o(o_rg1), .op2IsReg_o(o_rg2), .op3IsReg_o(o_rg3), .op4IsReg_o(o_rg4),
      .modifiesCR_o(o_cr), .body_o(o_body),
      .stall_o(stall_o), .overflow_o(overflow_o),
`ifdef DECODE_QUEUE_STATS_EN
      .pushCount_o(push_cnt_o), .popCount_o(pop_cnt_o), .dropCount_o(drop_cnt_o),
`endif
      .count_o(count_o)
   );

   int    n_checks = 0;
   int    n_fail   = 0;
   beat_t q[$];
   bit    m_stall  = 1'b0;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic beat_t rand_beat(input logic [63:0] maj);
      beat_t b;
      b.fmt  = 25'(1) << $urandom_range(24, 0);
      b.opc  = 12'($urandom);
      b.addr = {$urandom, $urandom};
      b.fu   = 3'($urandom_range(5, 0));
      b.maj  = maj;
      b.min  = 5'($urandom);
      b.nmu  = 5'($urandom);
      b.is64 = 1'($urandom);
      b.pid  = $urandom;
      b.tid  = {$urandom, $urandom};
      b.rw1  = 2'($urandom); b.rw2 = 2'($urandom); b.rw3 = 2'($urandom); b.rw4 = 2'($urandom);
      b.rg1  = 1'($urandom); b.rg2 = 1'($urandom); b.rg3 = 1'($urandom); b.rg4 = 1'($urandom);
      b.cr   = 1'($urandom);
      b.body = {$urandom, $urandom};
      return b;
   endfunction

   task automatic check_status();
      beat_t exp_head;
      chk("valid", valid_o, q.size() != 0);
      chk("count", count_o, q.size());
      chk("stall", stall_o, m_stall);
      if (q.size() != 0) exp_head = q[0];
      else               exp_head = '0;
      chk("head", out_b, exp_head);
`ifdef DECODE_QUEUE_STATS_EN
      chk("push_count", push_cnt_o, m_push_n);
      chk("pop_count",  pop_cnt_o,  m_pop_n);
      chk("drop_count", drop_cnt_o, m_drop_n);
`endif
   endtask

   // One clock: drive at negedge, check just after, apply the model at posedge.
   task automatic cycle(input bit en, input beat_t b, input bit rdy, input bit fl);
      bit pop, push, ovf;
      enable_i = en; in_b = b; ready_i = rdy; flush_i = fl;
      #1;
      check_status();
      pop  = (q.size() != 0) && rdy && !fl;
      push = en && !fl && (q.size() < DEPTH || pop);
      ovf  = en && !fl && (q.size() == DEPTH) && !pop;
      chk("overflow", overflow_o, ovf);
      @(posedge clock_i);
      if (fl) q.delete();
      else begin
         if (pop)  void'(q.pop_front());
         if (push) q.push_back(b);
      end
`ifdef DECODE_QUEUE_STATS_EN
      if (pop)  m_pop_n++;
      if (push) m_push_n++;
      if (ovf)  m_drop_n++;
`endif
      m_stall = (q.size() >= DEPTH - SLACK);
      @(negedge clock_i);
   endtask

   initial begin
      beat_t b;
      reset_i = 1'b1; flush_i = 1'b0; enable_i = 1'b0; ready_i = 1'b0; in_b = '0;
`ifdef DECODE_QUEUE_STATS_EN
      m_push_n = 0; m_pop_n = 0; m_drop_n = 0;
`endif
      #2;
      check_status();
      chk("reset_overflow", overflow_o, 1'b0);
      @(negedge clock_i);
      reset_i = 1'b0;

      // Single beat, visible next cycle, then drained.
      b = rand_beat(64'd5); b.opc = 12'h00E; b.body = 64'h1234;
      cycle(1, b, 1, 0);
      chk("single_maj", o_maj, 64'd5);
      chk("single_opc", o_opc, 12'h00E);
      chk("single_body", o_body, 64'h1234);
      cycle(0, '0, 1, 0);
      cycle(0, '0, 1, 0);

      // Fill to full, overflow on the 9th, drain in order.
      for (int i = 1; i <= 8; i++) cycle(1, rand_beat(64'(i)), 0, 0);
      chk("full_count", count_o, 4'd8);
      cycle(1, rand_beat(64'd9), 0, 0);
      chk("post_drop_count", count_o, 4'd8);
      for (int i = 1; i <= 8; i++) begin
         chk("drain_order", o_maj, 64'(i));
         cycle(0, '0, 1, 0);
      end
      cycle(0, '0, 1, 0);

      // Full with simultaneous pop: the push is accepted.
      for (int i = 1; i <= 8; i++) cycle(1, rand_beat(64'(i)), 0, 0);
      cycle(1, rand_beat(64'd9), 1, 0);
      chk("full_pushpop_count", count_o, 4'd8);
      chk("full_pushpop_head", o_maj, 64'd2);
      for (int i = 0; i < 9; i++) cycle(0, '0, 1, 0);

      // Wrap-around with continuous push and pop.
      for (int i = 0; i < 4; i++) cycle(1, rand_beat(64'(100 + i)), 0, 0);
      for (int i = 0; i < 20; i++) cycle(1, rand_beat(64'(200 + i)), 1, 0);
      chk("wrap_count", count_o, 4'd4);
      for (int i = 0; i < 5; i++) cycle(0, '0, 1, 0);

      // Flush with a concurrent push, then a normal push.
      for (int i = 0; i < 3; i++) cycle(1, rand_beat(64'(300 + i)), 0, 0);
      cycle(1, rand_beat(64'd399), 1, 1);
      chk("flush_count", count_o, 4'd0);
      chk("flush_valid", valid_o, 1'b0);
      cycle(1, rand_beat(64'd400), 0, 0);
      chk("after_flush_head", o_maj, 64'd400);
      cycle(0, '0, 1, 0);

      // Randomised traffic including occasional flushes.
      for (int i = 0; i < 300; i++)
         cycle($urandom_range(3, 0) != 0, rand_beat({$urandom, $urandom}),
               1'($urandom), $urandom_range(19, 0) == 0);
      for (int i = 0; i < 9; i++) cycle(0, '0, 1, 0);

      // Asynchronous reset mid-cycle with six entries held.
      for (int i = 0; i < 6; i++) cycle(1, rand_beat(64'(500 + i)), 0, 0);
      chk("pre_reset_stall", stall_o, 1'b1);
      enable_i = 1'b0;
      #2;
      reset_i = 1'b1;
      #1;
      q.delete(); m_stall = 1'b0;
`ifdef DECODE_QUEUE_STATS_EN
      m_push_n = 0; m_pop_n = 0; m_drop_n = 0;
`endif
      check_status();
      chk("async_reset_maj", o_maj, 64'd0);
      @(negedge clock_i);
      reset_i = 1'b0;
      cycle(1, rand_beat(64'd600), 0, 0);
      cycle(0, '0, 1, 0);
      cycle(0, '0, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_inst_queue.md
Name: decode_inst_queue

Overview:
- Consumer end of the decode-mux output stream.
- Captures each decoded instruction, presented as an enable-qualified beat with no backpressure, into a circular FIFO and drains it in order to dispatch/rename over a valid/ready handshake.
- Raises an early stall so the upstream fetch/decode pipeline can freeze before entries are lost.
- Supports a pipeline flush on branch mispredict or exception.

Parameters:
- depth, 8, number of entries; power of two, at least 4.
- stallSlack, 3, free entries still available when stall_o asserts; covers decode pipeline depth.
- opcodeSize, 12, opcode width.
- addressWidth, 64, instruction address width.
- instructionCounterWidth, 64, major ID width.
- instMinIdWidth, 5, minor ID and micro-op count width.
- PidSize, 32, process ID width.
- TidSize, 64, thread ID width.
- funcUnitCodeSize, 3, functional unit code width.
- regAccessPatternSize, 2, per-operand read/write flag width.
- formatWidth, 25, one-hot instruction format width.
- bodyWidth, 64, operand body width.

Ports:
- clock_i  in  1  clock.
- reset_i  in  1  asynchronous active-high reset.
- flush_i  in  1  synchronous queue clear.
- enable_i  in  1  decoded beat valid this cycle.
- instFormat_i  in  formatWidth  one-hot format.
- opcode_i  in  opcodeSize  opcode.
- address_i  in  addressWidth  instruction address.
- funcUnitType_i  in  funcUnitCodeSize  target unit.
- majID_i  in  instructionCounterWidth  major ID.
- minID_i, numMicroOps_i  in  instMinIdWidth each  minor ID and micro-op count.
- is64Bit_i  in  1  64-bit mode.
- pid_i  in  PidSize  process ID.
- tid_i  in  TidSize  thread ID.
- op1rw_i..op4rw_i  in  regAccessPatternSize each  operand access pattern.
- op1IsReg_i..op4IsReg_i  in  1 each  operand is a register.
- modifiesCR_i  in  1  writes the condition register.
- body_i  in  bodyWidth  operand body.
- ready_i  in  1  dispatch accepts the head entry.
- valid_o  out  1  head entry valid.
- For every _i field above there is a matching _o output, same name, same width, carrying the head entry.
- stall_o  out  1  upstream must stop issuing beats.
- overflow_o  out  1  one-cycle pulse: a beat was dropped.
- count_o  out  log2(depth)+1  current occupancy.

Behaviour:
- Reset (asynchronous, active-high):
  - Pointers and count go to 0.
  - valid_o, stall_o and overflow_o go to 0.
  - All payload outputs read as 0; storage is cleared or the outputs are gated by valid_o.
- Storage:
  - depth x entryWidth array.
  - Read and write pointers are log2(depth) bits and wrap naturally modulo depth.
  - count is tracked separately. full = (count == depth); empty = (count == 0).
- Push: enable_i && (!full || pop). The entry is written at wrPtr, then wrPtr increments.
- Pop: valid_o && ready_i. rdPtr increments.
- Output timing:
  - Payload outputs combinationally reflect mem[rdPtr].
  - valid_o = !empty.
- Latency:
  - A beat pushed in cycle N is visible at the head in cycle N+1 at the earliest.
  - There is no same-cycle bypass.
- Simultaneous push and pop:
  - count is unchanged.
  - When full, the push is accepted because a slot frees that cycle.
- Push while full without a pop:
  - The beat is discarded and overflow_o pulses high for one cycle.
  - Queue contents are unaffected.
- stall_o is registered: next value = (count_next >= depth - stallSlack).
- flush_i:
  - Takes priority over everything.
  - Next cycle count = 0 and rdPtr = wrPtr = 0; valid_o and stall_o are 0.
  - A push or pop in the flush cycle is ignored.
  - overflow_o is not asserted in the flush cycle.
- Ordering: strict FIFO. Entries are never reordered or modified.
- Reset mid-operation: all state is lost immediately; no partial entry survives.

Optional Feature:
- Macro: DECODE_QUEUE_STATS_EN.
- When defined:
  - Adds outputs pushCount_o, popCount_o and dropCount_o, 32 bits each, wrapping.
  - They increment on an accepted push, a pop, and a dropped beat respectively.
  - They reset to 0 on reset_i and are NOT cleared by flush_i.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package decode_pkg holds:
  - the format one-hot constants (I, B, D, A, ...);
  - the functional unit codes;
  - the regRead/regWrite constants;
  - the packed decoded-instruction entry typedef and its width, entryWidth = 352 at defaults.
- One sub-module, decode_fifo_ctrl, owns pointers, count, full/empty, stall and overflow. The top holds storage and the field pack/unpack.

Test Plan:
- Reset, then push one beat with majID=5, opcode=12'h00E, body=64'h1234 -> valid_o=1 the next cycle with identical fields; with ready_i=1 the queue drains and valid_o=0.
- With ready_i=0, push 8 beats with majID 1..8 -> count_o=8; stall_o asserts the cycle after count reaches 5; push a 9th -> overflow_o=1 for one cycle; then drain and see majIDs 1..8 in order, 9 absent.
- Full queue, push majID=9 with ready_i=1 in the same cycle -> head 1 pops, 9 is accepted, count_o stays 8, overflow_o=0.
- Push 4 beats, pop continuously for 20 cycles while pushing every cycle -> wrap-around preserves order; count never exceeds 4.
- Queue holding 3 entries, assert flush_i with enable_i=1 -> next cycle count_o=0, valid_o=0, the pushed beat is lost; a push the following cycle works normally.
- Assert reset_i asynchronously mid-cycle with 6 entries -> outputs go to 0 immediately without a clock edge. With DECODE_QUEUE_STATS_EN, the counters read 0 after reset but survive a flush.
